// File: rtl/dds_wave_meter.sv
// Gated waveform meter: counts Schmitt-qualified rising mid-level crossings,
// the clock span between first and last crossing, and sample min/max.
module dds_wave_meter #(
  parameter int MID  = 128,
  parameter int HYST = 8
) (
  input  logic        clk_dds,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] gate_len,
  input  logic        adc_valid,
  input  logic [7:0]  adc_data,
  output logic        busy,
  output logic        meas_done,
  output logic [15:0] cross_cnt,
  output logic [31:0] span_cyc,
  output logic [7:0]  vmax,
  output logic [7:0]  vmin,
  output logic        no_signal,
  output logic [1:0]  dbg_state_o
);

  // adc_valid is a one-way qualifier with no ready: the meter accepts every
  // valid sample on the cycle it is presented and never applies back-pressure.

  localparam logic [7:0] LO_TH = 8'(MID - HYST);
  localparam logic [7:0] HI_TH = 8'(MID + HYST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] gate_q, t_q, t_first_q, t_first_d, t_last_q, t_last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        armed_q, armed_d, seen_q, seen_d;
  logic [7:0]  max_q, max_d, min_q, min_d;
  logic        busy_q, meas_done_q, no_signal_q;
  logic [15:0] cross_cnt_q;
  logic [31:0] span_cyc_q;
  logic [7:0]  vmax_q, vmin_q;

  // Tracker updates for the current RUN cycle; also feeds the final result
  // so the sample on the last gate cycle is counted.
  always_comb begin
    cnt_d     = cnt_q;
    armed_d   = armed_q;
    seen_d    = seen_q;
    max_d     = max_q;
    min_d     = min_q;
    t_first_d = t_first_q;
    t_last_d  = t_last_q;
    if (state_q == S_RUN && adc_valid) begin
      seen_d = 1'b1;
      if (adc_data > max_q) max_d = adc_data;
      if (adc_data < min_q) min_d = adc_data;
      if (adc_data < LO_TH) begin
        armed_d = 1'b1;
      end else if (armed_q && adc_data >= HI_TH) begin
        armed_d = 1'b0;
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'd0) t_first_d = t_q;
        t_last_d = t_q;
      end
    end
  end

  always_ff @(posedge clk_dds) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gate_q      <= '0;
      t_q         <= '0;
      t_first_q   <= '0;
      t_last_q    <= '0;
      cnt_q       <= '0;
      armed_q     <= 1'b0;
      seen_q      <= 1'b0;
      max_q       <= 8'h00;
      min_q       <= 8'hFF;
      busy_q      <= 1'b0;
      meas_done_q <= 1'b0;
      cross_cnt_q <= '0;
      span_cyc_q  <= '0;
      vmax_q      <= '0;
      vmin_q      <= '0;
      no_signal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          meas_done_q <= 1'b0;
          if (start && !abort) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            gate_q  <= (gate_len == 32'd0) ? 32'd1 : gate_len;
            t_q     <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            seen_q  <= 1'b0;
            max_q   <= 8'h00;
            min_q   <= 8'hFF;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            t_q       <= t_q + 32'd1;
            cnt_q     <= cnt_d;
            armed_q   <= armed_d;
            seen_q    <= seen_d;
            max_q     <= max_d;
            min_q     <= min_d;
            t_first_q <= t_first_d;
            t_last_q  <= t_last_d;
            if (t_q == gate_q - 32'd1) begin
              state_q     <= S_DONE;
              meas_done_q <= 1'b1;
              cross_cnt_q <= cnt_d;
              span_cyc_q  <= (cnt_d >= 16'd2) ? (t_last_d - t_first_d) : 32'd0;
              no_signal_q <= (cnt_d < 16'd2);
              vmax_q      <= seen_d ? max_d : 8'h00;
              vmin_q      <= seen_d ? min_d : 8'h00;
            end
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          busy_q      <= 1'b0;
          meas_done_q <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign meas_done   = meas_done_q;
  assign cross_cnt   = cross_cnt_q;
  assign span_cyc    = span_cyc_q;
  assign vmax        = vmax_q;
  assign vmin        = vmin_q;
  assign no_signal   = no_signal_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dds_wave_meter.sv
// Directed bench for dds_wave_meter: square, constant, noise, alternating,
// empty gate, abort, reset mid-run and restart-while-busy cases.
module tb_dds_wave_meter;

  logic        clk_dds = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] gate_len = '0;
  logic        adc_valid = 1'b0;
  logic [7:0]  adc_data = '0;
  logic        busy, meas_done, no_signal;
  logic [15:0] cross_cnt;
  logic [31:0] span_cyc;
  logic [7:0]  vmax, vmin;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int early  = 0;

  dds_wave_meter dut (
    .clk_dds(clk_dds), .rst(rst), .start(start), .abort(abort),
    .gate_len(gate_len), .adc_valid(adc_valid), .adc_data(adc_data),
    .busy(busy), .meas_done(meas_done), .cross_cnt(cross_cnt),
    .span_cyc(span_cyc), .vmax(vmax), .vmin(vmin), .no_signal(no_signal),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk_dds = ~clk_dds;

  task automatic tick();
    @(posedge clk_dds);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // waveform modes: 0 square, 1 const 0x80, 2 noise 79/87, 3 77/88, 4 no valid
  function automatic logic [7:0] wave(input int mode, input int k);
    case (mode)
      0:       return ((k % 100) < 50) ? 8'h20 : 8'hE0;
      1:       return 8'h80;
      2:       return (k % 2 == 0) ? 8'h79 : 8'h87;
      3:       return (k % 2 == 0) ? 8'h77 : 8'h88;
      default: return 8'h5A;
    endcase
  endfunction

  // driver: accept start, then first RUN cycle begins
  task automatic do_start(input logic [31:0] g);
    start    = 1'b1;
    gate_len = g;
    tick();
    start    = 1'b0;
    gate_len = $urandom_range(0, 32'hFFFF);
  endtask

  // drive n RUN cycles; optional extra start pulse on cycle restart_at
  task automatic drive(input int n, input int mode, input int restart_at);
    for (int k = 0; k < n; k++) begin
      adc_valid = (mode != 4);
      adc_data  = wave(mode, k);
      start     = (k == restart_at);
      tick();
      if (k < n - 1 && meas_done) early++;
    end
    start     = 1'b0;
    adc_valid = 1'b0;
  endtask

  task automatic chk_results(input string tag, input logic [15:0] c, input logic [31:0] s,
                             input logic [7:0] mx, input logic [7:0] mn, input logic ns);
    chk({tag, "_cross"}, 32'(cross_cnt), 32'(c));
    chk({tag, "_span"}, span_cyc, s);
    chk({tag, "_vmax"}, 32'(vmax), 32'(mx));
    chk({tag, "_vmin"}, 32'(vmin), 32'(mn));
    chk({tag, "_nosig"}, 32'(no_signal), 32'(ns));
  endtask

  initial begin
    // reset state
    tick(); tick();
    rst = 1'b0;
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(meas_done), 32'd0);
    chk_results("rst", 16'd0, 32'd0, 8'h00, 8'h00, 1'b0);

    // square wave, gate 1000: meas_done at T+1001
    do_start(32'd1000);
    chk("sq_busy_rise", 32'(busy), 32'd1);
    early = 0;
    drive(1000, 0, -1);
    chk("sq_early_done", 32'(early), 32'd0);
    chk("sq_done", 32'(meas_done), 32'd1);
    chk_results("sq", 16'd10, 32'd900, 8'hE0, 8'h20, 1'b0);
    tick();
    chk("sq_busy_fall", 32'(busy), 32'd0);
    chk("sq_done_pulse", 32'(meas_done), 32'd0);

    // abort at RUN cycle 300: no meas_done, old results kept
    do_start(32'd1000);
    drive(300, 3, -1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(meas_done), 32'd0);
    chk_results("ab", 16'd10, 32'd900, 8'hE0, 8'h20, 1'b0);

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; gate_len = 32'd10;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", 32'(busy), 32'd0);
    chk("sa_state", 32'(dbg_state), 32'd0);

    // constant mid-level
    do_start(32'd500);
    drive(500, 1, -1);
    chk("const_done", 32'(meas_done), 32'd1);
    chk_results("const", 16'd0, 32'd0, 8'h80, 8'h80, 1'b1);
    tick();

    // noise inside hysteresis
    do_start(32'd200);
    drive(200, 2, -1);
    chk("noise_done", 32'(meas_done), 32'd1);
    chk_results("noise", 16'd0, 32'd0, 8'h87, 8'h79, 1'b1);
    tick();

    // alternating past thresholds, with an ignored start mid-run
    do_start(32'd200);
    early = 0;
    drive(200, 3, 50);
    chk("alt_early_done", 32'(early), 32'd0);
    chk("alt_done", 32'(meas_done), 32'd1);
    chk_results("alt", 16'd100, 32'd198, 8'h88, 8'h77, 1'b0);
    tick();
    chk("alt_idle", 32'(busy), 32'd0);

    // reset mid-RUN zeroes everything
    do_start(32'd1000);
    drive(100, 0, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(meas_done), 32'd0);
    chk_results("mrst", 16'd0, 32'd0, 8'h00, 8'h00, 1'b0);
    tick();

    // gate_len 0 with no valid samples: one RUN cycle, done at T+2
    do_start(32'd0);
    chk("g0_run_nodone", 32'(meas_done), 32'd0);
    drive(1, 4, -1);
    chk("g0_done", 32'(meas_done), 32'd1);
    chk_results("g0", 16'd0, 32'd0, 8'h00, 8'h00, 1'b1);
    tick();
    chk("g0_busy_fall", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dds_wave_meter.md
# dds_wave_meter

Measurement counterpart of the DDS generator: consumes an 8-bit offset-binary waveform stream, such as DDS loop-back or ADC samples, over a programmable gate window. It reports the rising mid-level crossing count, the clock span between the first and last crossing, and the min/max sample values. Software derives frequency (cross_cnt−1)·f_clk/span_cyc and amplitude from these results.

## Interface
- MID, 128: mid-level threshold, offset-binary centre.
- HYST, 8: hysteresis half-width in LSB; low-arm below MID−HYST, crossing at ≥ MID+HYST.
- clk_dds  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a measurement when idle, ignored while busy.
- abort  in  1  cancels a running measurement.
- gate_len  in  32  gate length in clocks, sampled on accepted start; 0 treated as 1.
- adc_valid  in  1  qualifies adc_data.
- adc_data  in  8  unsigned offset-binary sample.
- busy  out  1  high in RUN and DONE.
- meas_done  out  1  one-cycle pulse when results update.
- cross_cnt  out  16  rising crossings in gate, saturates at 0xFFFF.
- span_cyc  out  32  t_last − t_first in clocks.
- vmax  out  8  largest valid sample in gate.
- vmin  out  8  smallest valid sample in gate.
- no_signal  out  1  high when cross_cnt < 2.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on start=1 with abort=0. On entry: latch gate_len; clear t (RUN clock index, 32-bit); clear crossing count and lo_armed; set max tracker to 0x00, min tracker to 0xFF; clear seen_valid.
- RUN: t increments every clock, whether or not a sample is valid. Each valid sample updates the min/max trackers and sets seen_valid.
- Schmitt detector, valid samples only:
  - adc_data < MID−HYST sets lo_armed.
  - lo_armed and adc_data ≥ MID+HYST is a rising crossing at index t: clear lo_armed, increment count (saturating), record t_first if this is the first crossing, always record t_last.
  - A crossing needs a prior low sample inside the same gate.
- RUN → DONE on the cycle t = gate_len−1. That cycle's sample is still processed.
- RUN → IDLE on abort=1. No meas_done; outputs keep their previous results.
- DONE: register all results, pulse meas_done, then go to IDLE.
  - cross_cnt = count.
  - span_cyc = t_last − t_first if count ≥ 2, else 0.
  - no_signal = (count < 2).
  - If seen_valid=0: vmax=vmin=0.
- Outputs hold between measurements; only DONE updates them.
- Priority: rst > abort > start. start during RUN/DONE is ignored; abort in IDLE/DONE is ignored.

## Timing
- Reset: state IDLE. busy, meas_done, cross_cnt, span_cyc, vmax, vmin, no_signal all 0.
- start accepted at cycle T → RUN occupies T+1 … T+gate_len → meas_done and new results at T+gate_len+1 → IDLE at T+gate_len+2. A new start is accepted at T+gate_len+2 at the earliest.
- busy rises at T+1 and falls at T+gate_len+2.
- Sample at RUN cycle T+1+k has index t=k.
- rst mid-RUN: immediate return to reset state with outputs zeroed, no meas_done.
- t cannot overflow, since gate_len ≤ 2^32−1.

## Test plan
- Square wave: 0x20 for t 0–49, 0xE0 for t 50–99, period 100, valid every clock, gate_len=1000 → meas_done at T+1001; cross_cnt=10, span_cyc=900, vmax=0xE0, vmin=0x20, no_signal=0.
- Constant 0x80, gate_len=500 → cross_cnt=0, span_cyc=0, vmax=vmin=0x80, no_signal=1.
- Noise alternating 0x79/0x87, inside hysteresis, gate_len=200 → cross_cnt=0, no_signal=1. Then 0x77/0x88, period 2 starting low → crossings every 2 clocks, cross_cnt=100, span_cyc=198.
- adc_valid=0 throughout, gate_len=0 → RUN lasts 1 cycle; meas_done at T+2; vmax=vmin=0, no_signal=1.
- abort at RUN cycle 300 of gate_len=1000 → no meas_done, prior results unchanged, busy low next cycle. start+abort in the same IDLE cycle → stays IDLE.
- rst asserted mid-RUN → all outputs 0 next cycle. A second start during RUN is ignored, and meas_done timing is unchanged.
